// File: rtl/lsu_pkg.sv
// Shared encodings and the alignment rule for the load/store unit.
package lsu_pkg;

    localparam int unsigned SizeW = 2;
    localparam int unsigned WordW = 32;

    localparam logic [SizeW-1:0] SZ_BYTE = 2'b00;
    localparam logic [SizeW-1:0] SZ_HALF = 2'b01;
    localparam logic [SizeW-1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_RESP = 2'b11
    } state_e;

    // Size 2'b11 is never legal; otherwise the access must sit inside one word lane group.
    function automatic logic misaligned(input logic [SizeW-1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane select/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [SizeW-1:0] size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       offset_i,
    input  logic [WordW-1:0] rdata_i,
    input  logic [WordW-1:0] wdata_i,
    output logic [WordW-1:0] load_data_c_o,
    output logic [WordW-1:0] merge_data_c_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel       = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel       = rdata_i[{offset_i[1], 4'b0000} +: 16];
        load_data_c_o  = rdata_i;
        merge_data_c_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_c_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
                merge_data_c_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_c_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
                merge_data_c_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_data_c_o  = rdata_i;
                merge_data_c_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word CPU loads and stores into whole-word memory accesses,
// using read-modify-write for sub-word stores and rejecting misaligned requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned width     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [width-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [width-1:0]     resp_rdata,
    output logic                 resp_error,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [width-1:0]     mem_wdata,
    input  logic [width-1:0]     mem_rdata
);

    state_e                 state_q;
    logic                   ready_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [SizeW-1:0]       size_q;
    logic                   unsigned_q;
    logic                   write_q;
    logic [width-1:0]       wdata_q;
    logic                   resp_valid_q;
    logic                   resp_error_q;
    logic [width-1:0]       resp_rdata_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [AddrWidth-1:0]   mem_addr_q;
    logic [width-1:0]       mem_wdata_q;
    logic [width-1:0]       load_data;
    logic [width-1:0]       merge_data;

    // Lane logic works on the word being read this cycle and the latched request.
    lsu_lane_align u_lane_align (
        .size_i         (size_q),
        .unsigned_i     (unsigned_q),
        .offset_i       (addr_q[1:0]),
        .rdata_i        (mem_rdata),
        .wdata_i        (wdata_q),
        .load_data_c_o  (load_data),
        .merge_data_c_o (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            addr_q       <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ready_q    <= 1'b0;
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_write && req_size == SZ_WORD) begin
                            state_q     <= S_WR;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {req_addr[AddrWidth-1:2], 2'b00};
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= S_RD;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {req_addr[AddrWidth-1:2], 2'b00};
                        end
                    end
                end
                S_RD: begin
                    mem_read_q <= 1'b0;
                    if (write_q) begin
                        state_q     <= S_WR;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {addr_q[AddrWidth-1:2], 2'b00};
                        mem_wdata_q <= merge_data;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_rdata_q <= load_data;
                    end
                end
                S_WR: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a word-array reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory (64 words, commits on negedge) plus a preload port.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, bad_addr_cnt = 0, resp_cnt = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

    always @(posedge clk) begin
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
        if ((mem_read || mem_write) && (mem_addr[1:0] != 2'b00 || mem_addr[31:8] != 24'd0))
            bad_addr_cnt <= bad_addr_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: a request's effect on the word array and its response data.
    function automatic void ref_access(input logic w, input logic [1:0] sz, input logic u,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic err, output logic [31:0] rd);
        int          sh;
        logic [31:0] word, mask, v;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd  = 32'd0;
        if (err) return;
        sh   = 8 * int'(a[1:0]);
        word = ref_mem[a[7:2]];
        mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (w) begin
            ref_mem[a[7:2]] = (word & ~(mask << sh)) | ((d & mask) << sh);
        end else begin
            v = (word >> sh) & mask;
            if (!u && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (!u && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        pl_idx       = 6'(idx);
        pl_data      = v;
        pl_en        = 1'b1;
        ref_mem[idx] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
    endtask

    // One request from an idle negedge through its response; inputs are scrambled while busy.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        logic        err;
        logic [31:0] rd;
        int          lat, exp_lat, rd0, wr0, exp_rds, exp_wrs;
        ref_access(w, sz, u, a, d, err, rd);
        exp_lat = err ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        exp_rds = (err || (w && sz == 2'd2)) ? 0 : 1;
        exp_wrs = (!err && w) ? 1 : 0;
        check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive_req(w, sz, u, a, d);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom);
        req_write = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".error"}, 32'(resp_error), 32'(err));
        check_eq({tag, ".rdata"}, resp_rdata, rd);
        check_eq({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(exp_rds));
        check_eq({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_wrs));
        if (exp_wrs == 1) begin
            check_eq({tag, ".waddr"}, last_waddr, {a[31:2], 2'b00});
            check_eq({tag, ".wdata"}, last_wdata, ref_mem[a[7:2]]);
        end
        @(negedge clk);
        check_eq({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic reset_mid_op();
        int wr0;
        wr0 = wr_cnt;
        drive_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h77);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rst.in_rd", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst.mem_read", 32'(mem_read), 32'd0);
        check_eq("rst.mem_write", 32'(mem_write), 32'd0);
        check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst.mem_addr", mem_addr, 32'd0);
        check_eq("rst.mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst.no_write", 32'(wr_cnt - wr0), 32'd0);
        check_eq("rst.mem_word", mem[8], ref_mem[8]);
        check_eq("rst.ready", 32'(req_ready), 32'd1);
    endtask

    // Three queued requests with req_valid held and req_addr scrambled while busy.
    task automatic back_to_back();
        logic        qw[3], qu[3], eerr[3];
        logic [1:0]  qs[3];
        logic [31:0] qa[3], qd[3], erd[3];
        int          issued, seen, cyc, r0;
        qw[0] = 1'b1; qs[0] = 2'd0; qu[0] = 1'b0; qa[0] = 32'h41; qd[0] = 32'h0000_00A5;
        qw[1] = 1'b0; qs[1] = 2'd2; qu[1] = 1'b0; qa[1] = 32'h40; qd[1] = 32'h0;
        qw[2] = 1'b0; qs[2] = 2'd1; qu[2] = 1'b0; qa[2] = 32'h40; qd[2] = 32'h0;
        for (int i = 0; i < 3; i++) ref_access(qw[i], qs[i], qu[i], qa[i], qd[i], eerr[i], erd[i]);
        issued = 0;
        seen   = 0;
        cyc    = 0;
        r0     = resp_cnt;
        while (seen < 3 && cyc < 40) begin
            if (resp_valid) begin
                check_eq($sformatf("b2b%0d.rdata", seen), resp_rdata, erd[seen]);
                check_eq($sformatf("b2b%0d.error", seen), 32'(resp_error), 32'(eerr[seen]));
                seen++;
            end
            if (req_ready && issued < 3) begin
                drive_req(qw[issued], qs[issued], qu[issued], qa[issued], qd[issued]);
                issued++;
            end else begin
                req_addr  = $urandom;
                req_wdata = $urandom;
                if (issued == 3) req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        check_eq("b2b.seen", 32'(seen), 32'd3);
        repeat (3) @(negedge clk);
        check_eq("b2b.pulses", 32'(resp_cnt - r0), 32'd3);
        check_eq("b2b.mem", mem[16], ref_mem[16]);
    endtask

    initial begin
        logic        w, u;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        rst_n = 1'b1;
        drive_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset.ready", 32'(req_ready), 32'd1);
        check_eq("reset.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("reset.resp_error", 32'(resp_error), 32'd0);
        check_eq("reset.resp_rdata", resp_rdata, 32'd0);
        check_eq("reset.mem_read", 32'(mem_read), 32'd0);
        check_eq("reset.mem_write", 32'(mem_write), 32'd0);
        check_eq("reset.mem_addr", mem_addr, 32'd0);
        check_eq("reset.mem_wdata", mem_wdata, 32'd0);

        @(negedge clk);
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(4, 32'h0);
        preload(32, 32'h12F4_5678);
        preload(8, 32'h1122_3344);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("sw_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req("lw_word", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_eq("lw_word.const", resp_rdata, 32'hDEAD_BEEF);
        do_req("lb_signed", 1'b0, 2'd0, 1'b0, 32'h82, 32'h0);
        check_eq("lb_signed.const", resp_rdata, 32'hFFFF_FFF4);
        do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h82, 32'h0);
        check_eq("lbu.const", resp_rdata, 32'h0000_00F4);
        do_req("sh_rmw", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_AABB);
        check_eq("sh_rmw.const", last_wdata, 32'hAABB_3344);
        do_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h21, 32'h0);
        do_req("sh_mis", 1'b1, 2'd1, 1'b0, 32'h23, 32'h1234);
        do_req("ld_ill", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        do_req("st_ill", 1'b1, 2'd3, 1'b1, 32'h44, 32'h5555);

        reset_mid_op();
        back_to_back();

        for (int n = 0; n < 80; n++) begin
            w  = 1'($urandom);
            u  = 1'($urandom);
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 7) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : ((sz == 2'd2) ? 2'b00 : a[1:0]);
            do_req($sformatf("rnd%0d", n), w, sz, u, a, $urandom);
        end

        for (int i = 0; i < 64; i++) check_eq($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);
        check_eq("never_both", 32'(both_cnt), 32'd0);
        check_eq("addr_aligned", 32'(bad_addr_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
